// File: rtl/stage_data_pkg.sv
// Shared opcode constants for the data stage.
// One-hot operation bit indices and a helper that classifies cell reads.
package stage_data_pkg;

    localparam int OP_INC       = 0;
    localparam int OP_DEC       = 1;
    localparam int OP_INCDP     = 2;
    localparam int OP_DECDP     = 3;
    localparam int OP_OUT       = 4;
    localparam int OP_IN        = 5;
    localparam int OP_LOOPBEGIN = 6;
    localparam int OP_LOOPEND   = 7;
    localparam int OP_NOP       = 8;
    localparam int OPCODE_MSB   = 8;

    // Operations that must fetch the current cell before completing.
    function automatic logic needs_read(
        input logic [OPCODE_MSB:0] op
    );
        return op[OP_INC] | op[OP_DEC] | op[OP_OUT]
             | op[OP_LOOPBEGIN] | op[OP_LOOPEND];
    endfunction

endpackage

// File: rtl/stage_data_if.sv
// Data-memory bus between the data stage and the cell memory.
// master: stage (addr/strobes/wdata out, rdata in); slave: memory.
interface stage_data_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_re,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/stage_data.sv
// Data stage: cell read-modify-write, '.' output, ',' input, zero flag.
// Ports: clk/reset, upstream op/dp/drdy_in/ack, mem bus, out_*, in_*, downstream op/zero/drdy/ack_in.
module stage_data
    import stage_data_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_MSB:0]   operation_in,
    input  logic                  drdy_in,
    output logic                  ack,
    input  logic [ADDR_WIDTH-1:0] dp,
    stage_data_if.master          mem,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OPCODE_MSB:0]   operation,
    output logic                  zero,
    output logic                  drdy,
    input  logic                  ack_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MODIFY,
        S_OUT_WAIT,
        S_IN_WAIT,
        S_HOLD
    } state_t;

    state_t                state;
    logic [OPCODE_MSB:0]   op_q;
    logic [ADDR_WIDTH-1:0] dp_q;
    logic [DATA_WIDTH-1:0] cell_new;
    logic                  is_rmw;
    logic                  in_xfer;
    logic                  rmw_we;

    assign is_rmw  = op_q[OP_INC] | op_q[OP_DEC];
    assign in_xfer = (state == S_IN_WAIT) && in_valid;
    assign rmw_we  = (state == S_MODIFY) && is_rmw;

    // Final cell value after the MODIFY step (unchanged for non +/-).
    always_comb begin
        cell_new = mem.mem_rdata;
        if (op_q[OP_INC]) begin
            cell_new = mem.mem_rdata + DATA_WIDTH'(1);
        end else if (op_q[OP_DEC]) begin
            cell_new = mem.mem_rdata - DATA_WIDTH'(1);
        end
    end

    // Strobes are gated by reset so an in-flight write or transfer
    // is dropped on the very edge that resets the stage.
    assign mem.mem_addr = dp_q;
    assign mem.mem_re   = !reset && (state == S_READ);
    assign mem.mem_we   = !reset && (rmw_we || in_xfer);
    assign out_valid    = !reset && (state == S_OUT_WAIT);
    assign in_ready     = !reset && (state == S_IN_WAIT);
    assign drdy         = (state == S_HOLD);
    assign operation    = op_q;

    always_comb begin
        mem.mem_wdata = '0;
        if (!reset && in_xfer) begin
            mem.mem_wdata = in_data;
        end else if (!reset && rmw_we) begin
            mem.mem_wdata = cell_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            dp_q     <= '0;
            ack      <= 1'b0;
            zero     <= 1'b0;
            out_data <= '0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (drdy_in) begin
                        op_q <= operation_in;
                        dp_q <= dp;
                        ack  <= 1'b1;
                        zero <= 1'b0;
                        if (operation_in[OP_IN]) begin
                            state <= S_IN_WAIT;
                        end else if (needs_read(operation_in)) begin
                            state <= S_READ;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_READ: begin
                    state <= S_MODIFY;
                end
                S_MODIFY: begin
                    zero <= (cell_new == '0);
                    if (op_q[OP_OUT]) begin
                        out_data <= mem.mem_rdata;
                        state    <= S_OUT_WAIT;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        state <= S_HOLD;
                    end
                end
                S_IN_WAIT: begin
                    if (in_valid) begin
                        zero  <= (in_data == '0);
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ack_in) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_data.sv
// Testbench for stage_data: directed plan steps plus random operations.
// Memory model on the bus; expected cells/zero/latency from a high-level model.
module tb_stage_data;
    import stage_data_pkg::*;

    logic                clk;
    logic                reset;
    logic [OPCODE_MSB:0] operation_in;
    logic                drdy_in;
    logic                ack;
    logic [11:0]         dp;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_MSB:0] operation;
    logic                zero;
    logic                drdy;
    logic                ack_in;

    stage_data_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) bus ();

    stage_data #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .operation_in (operation_in),
        .drdy_in      (drdy_in),
        .ack          (ack),
        .dp           (dp),
        .mem          (bus),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operation    (operation),
        .zero         (zero),
        .drdy         (drdy),
        .ack_in       (ack_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-side memory with 1-cycle read latency plus a poke port.
    logic [7:0]  mem [0:4095];
    logic        poke_en;
    logic [11:0] poke_a;
    logic [7:0]  poke_d;
    int          we_cnt;
    int          re_cnt;
    int          ox_cnt;
    int          both_cnt;
    int          hold_bad;

    initial begin
        we_cnt = 0; re_cnt = 0; ox_cnt = 0;
        both_cnt = 0; hold_bad = 0;
    end

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        if (poke_en) mem[poke_a] = poke_d;
        if (bus.mem_we) we_cnt++;
        if (bus.mem_re) re_cnt++;
        if (out_valid && out_ready) ox_cnt++;
        if (bus.mem_re && bus.mem_we) both_cnt++;
        if (drdy && (bus.mem_re || bus.mem_we || out_valid || in_ready))
            hold_bad++;
    end

    logic [7:0] model [0:15];
    int total;
    int bad;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        model[a[3:0]] = d;
    endtask

    task automatic wait_ack();
        bit got;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; break; end
        end
        chk("ack_seen", 64'(got), 64'(1));
    endtask

    task automatic do_op(input int opb, input logic [11:0] a,
                         input int w, input logic [7:0] din);
        logic [OPCODE_MSB:0] opv;
        logic [7:0] old, nv;
        logic ez, rd, wr;
        int exp_lat, t, we0, re0, ox0, ovc, irc;
        bit got;
        opv = (OPCODE_MSB+1)'(1) << opb;
        old = model[a[3:0]];
        rd = (opb == OP_INC) || (opb == OP_DEC) || (opb == OP_OUT)
          || (opb == OP_LOOPBEGIN) || (opb == OP_LOOPEND);
        wr = (opb == OP_INC) || (opb == OP_DEC) || (opb == OP_IN);
        nv = old;
        if (opb == OP_INC) nv = 8'((int'(old) + 1) % 256);
        if (opb == OP_DEC) nv = 8'((int'(old) + 255) % 256);
        if (opb == OP_IN) nv = din;
        ez = (rd || wr) ? (nv == 8'h00) : 1'b0;
        if (opb == OP_OUT) exp_lat = 3 + w;
        else if (opb == OP_IN) exp_lat = 1 + w;
        else if (rd) exp_lat = 2;
        else exp_lat = 0;
        we0 = we_cnt; re0 = re_cnt; ox0 = ox_cnt;
        operation_in = opv; dp = a; drdy_in = 1'b1;
        wait_ack();
        drdy_in = 1'b0; operation_in = '0;
        t = 0; ovc = 0; irc = 0; got = 0;
        for (int i = 0; i < 60; i++) begin
            if (drdy) begin got = 1; break; end
            if (t == 1) chk("ack_pulse", 64'(ack), 64'(0));
            if (out_valid) begin
                ovc++;
                if (ovc == w + 1) begin
                    out_ready = 1'b1;
                    chk("out_data", 64'(out_data), 64'(old));
                end
            end else out_ready = 1'b0;
            if (in_ready) begin
                irc++;
                if (irc == w + 1) begin
                    in_valid = 1'b1; in_data = din;
                end
            end else in_valid = 1'b0;
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b0; in_valid = 1'b0;
        chk("drdy_seen", 64'(got), 64'(1));
        chk("latency", 64'(t), 64'(exp_lat));
        chk("operation", 64'(operation), 64'(opv));
        chk("zero", 64'(zero), 64'(ez));
        if (opb == OP_OUT) chk("out_cycles", 64'(ovc), 64'(w + 1));
        if (opb == OP_IN) chk("in_cycles", 64'(irc), 64'(w + 1));
        chk("out_xfers", 64'(ox_cnt - ox0), 64'(opb == OP_OUT));
        chk("writes", 64'(we_cnt - we0), 64'(wr));
        chk("reads", 64'(re_cnt - re0), 64'(rd));
        if (rd || wr) chk("cell", 64'(mem[a]), 64'(nv));
        model[a[3:0]] = nv;
        repeat (2) begin @(posedge clk); #1; end
        chk("hold", 64'({drdy, operation, zero, ack, in_ready, out_valid,
                         bus.mem_re, bus.mem_we}),
            64'({1'b1, opv, ez, 5'b0}));
        ack_in = 1'b1;
        @(posedge clk); #1;
        ack_in = 1'b0;
        chk("release", 64'(drdy), 64'(0));
    endtask

    function automatic logic [43:0] outs();
        return {ack, drdy, zero, operation, bus.mem_re, bus.mem_we,
                out_valid, in_ready, bus.mem_addr, bus.mem_wdata, out_data};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int we0, re0, ox0, cnt;
        bit got;
        total = 0; bad = 0;
        reset = 1'b1; operation_in = '0; drdy_in = 1'b0; dp = '0;
        out_ready = 1'b0; in_data = '0; in_valid = 1'b0; ack_in = 1'b0;
        poke_en = 1'b0; poke_a = '0; poke_d = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'(outs()), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 16; i++) poke(12'(i), 8'h00);

        // Stray ack_in while nothing is pending.
        ack_in = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        ack_in = 1'b0;
        chk("idle_ack_in", 64'({drdy, ack}), 64'(0));

        // Plan steps 1-4.
        poke(12'd5, 8'hFF);
        do_op(OP_INC, 12'd5, 0, 8'h00);
        poke(12'd7, 8'h00);
        do_op(OP_DEC, 12'd7, 0, 8'h00);
        do_op(OP_LOOPBEGIN, 12'd7, 0, 8'h00);
        poke(12'd3, 8'h41);
        do_op(OP_OUT, 12'd3, 4, 8'h00);
        poke(12'd10, 8'h33);
        do_op(OP_IN, 12'd10, 2, 8'h00);

        // Step 5: INCDP then INC with ack_in held high.
        we0 = we_cnt; re0 = re_cnt;
        ack_in = 1'b1;
        operation_in = (OPCODE_MSB+1)'(1) << OP_INCDP;
        dp = 12'h123; drdy_in = 1'b1;
        wait_ack();
        chk("b2b_dp_drdy", 64'({drdy, operation, zero}),
            64'({1'b1, (OPCODE_MSB+1)'(1) << OP_INCDP, 1'b0}));
        operation_in = (OPCODE_MSB+1)'(1) << OP_INC; dp = 12'd5;
        @(posedge clk); #1;
        chk("b2b_bubble", 64'({ack, drdy}), 64'(0));
        chk("b2b_dp_noread", 64'(re_cnt - re0), 64'(0));
        @(posedge clk); #1;
        chk("b2b_ack2", 64'(ack), 64'(1));
        drdy_in = 1'b0; operation_in = '0;
        cnt = 0; got = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; cnt++;
            if (drdy) begin got = 1; break; end
        end
        chk("b2b_inc_lat", 64'({got, 8'(cnt)}), 64'({1'b1, 8'd2}));
        chk("b2b_inc_zero", 64'(zero), 64'(0));
        @(posedge clk); #1;
        chk("b2b_drop", 64'(drdy), 64'(0));
        ack_in = 1'b0;
        model[5] = 8'((int'(model[5]) + 1) % 256);
        chk("b2b_cell", 64'(mem[5]), 64'(model[5]));
        chk("b2b_writes", 64'(we_cnt - we0), 64'(1));

        // Step 6a: reset while in MODIFY of an INC.
        poke(12'd9, 8'h10);
        we0 = we_cnt;
        operation_in = (OPCODE_MSB+1)'(1) << OP_INC; dp = 12'd9;
        drdy_in = 1'b1;
        wait_ack();
        drdy_in = 1'b0; operation_in = '0;
        @(posedge clk); #1;
        chk("modify_we", 64'(bus.mem_we), 64'(1));
        reset = 1'b1; #1;
        chk("rst_gate_we", 64'(bus.mem_we), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mod_outs", 64'(outs()), 64'(0));
        chk("rst_mod_cell", 64'(mem[9]), 64'(8'h10));
        chk("rst_mod_wr", 64'(we_cnt - we0), 64'(0));

        // Step 6b: reset while in OUT_WAIT.
        ox0 = ox_cnt;
        operation_in = (OPCODE_MSB+1)'(1) << OP_OUT; dp = 12'd3;
        drdy_in = 1'b1;
        wait_ack();
        drdy_in = 1'b0; operation_in = '0;
        repeat (2) begin @(posedge clk); #1; end
        chk("outwait_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1; reset = 1'b1; #1;
        chk("rst_gate_out", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b0;
        chk("rst_out_outs", 64'(outs()), 64'(0));
        chk("rst_out_xfer", 64'(ox_cnt - ox0), 64'(0));
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_stay_idle", 64'({drdy, out_valid, bus.mem_re}), 64'(0));

        // Random operations over a small cell window.
        for (int i = 0; i < 16; i++) begin
            int k;
            logic [7:0] v;
            k = int'($urandom_range(0, 3));
            v = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom);
            poke(12'(i), v);
        end
        for (int n = 0; n < 40; n++) begin
            int opb, w;
            logic [11:0] a;
            logic [7:0] din;
            opb = int'($urandom_range(0, 8));
            a = 12'($urandom_range(0, 15));
            w = int'($urandom_range(0, 3));
            din = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            do_op(opb, a, w, din);
        end

        chk("never_re_we", 64'(both_cnt), 64'(0));
        chk("quiet_in_hold", 64'(hold_bad), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_data.md
Name: stage_data

Overview:
- Pipeline stage that sits directly downstream of the data-pointer modify stage.
- Takes the one-hot operation and the already-updated data pointer from that stage and performs the data-memory part of the instruction: cell read-modify-write for +/-, output for '.', input for ','.
- Reports the cell-zero flag that the loop/branch stage consumes.
- Runs a valid/ack handshake toward both the upstream and downstream stages.

Parameters:
- DATA_WIDTH, 8, width of a memory cell and of the I/O data.
- ADDR_WIDTH, 12, width of the data pointer and of the memory address.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- operation_in  in  OPCODE_MSB+1  one-hot opcode from the modify stage
- drdy_in  in  1  upstream has a valid operation
- ack  out  1  one-cycle pulse: operation accepted
- dp  in  ADDR_WIDTH  current data pointer; stable while drdy_in=1
- mem_addr  out  ADDR_WIDTH  data memory address
- mem_re  out  1  read strobe; memory has 1-cycle synchronous read latency
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_re
- mem_we  out  1  write strobe
- mem_wdata  out  DATA_WIDTH  write data
- out_data  out  DATA_WIDTH  byte for '.'
- out_valid  out  1  out_data valid
- out_ready  in  1  output sink accepts
- in_data  in  DATA_WIDTH  byte for ','
- in_valid  in  1  input source has a byte
- in_ready  out  1  stage waiting for input
- operation  out  OPCODE_MSB+1  completed operation, to the next stage
- zero  out  1  final cell value == 0; valid while drdy=1
- drdy  out  1  operation and zero valid for the next stage
- ack_in  in  1  next stage accepted

Behaviour:
- States: IDLE, READ, MODIFY, OUT_WAIT, IN_WAIT, HOLD. Encoding is binary and internal to the block.
- Reset state: IDLE. All outputs are 0: ack, drdy, zero, operation, mem_re, mem_we, out_valid, in_ready, mem_addr, mem_wdata, out_data.
- IDLE, drdy_in=1:
  - Latch operation_in and dp; ack=1 for exactly the next cycle.
  - Next state:
    - OP_IN -> IN_WAIT.
    - OP_INC, OP_DEC, OP_OUT, OP_LOOPBEGIN, OP_LOOPEND -> READ.
    - Any other opcode (INCDP, DECDP, NOP) -> HOLD, with zero=0.
- READ: mem_re=1, mem_addr=latched dp. Next state MODIFY.
- MODIFY: cell = mem_rdata.
  - INC: mem_we=1, mem_wdata = cell+1 mod 2^DATA_WIDTH (0xFF -> 0x00).
  - DEC: mem_we=1, mem_wdata = cell-1 mod 2^DATA_WIDTH (0x00 -> 0xFF).
  - zero is registered from the final cell value (after any write).
  - OUT: latch out_data=cell, go to OUT_WAIT. All others go to HOLD.
- OUT_WAIT: out_valid=1. When out_valid && out_ready -> HOLD; out_valid drops the following cycle.
- IN_WAIT: in_ready=1. When in_valid && in_ready: mem_we=1, mem_wdata=in_data, zero=(in_data==0), -> HOLD.
- HOLD: drdy=1 with the operation and zero outputs held stable. When ack_in=1 -> IDLE, drdy=0 next cycle.
- No new acceptance while not IDLE. drdy_in is ignored outside IDLE, so the upstream must hold drdy_in until it sees ack.
- If ack_in and a new drdy_in arrive in the same HOLD cycle, the new operation is accepted in the following IDLE cycle (one-cycle bubble).
- Latency, acceptance cycle to drdy:
  - INC, DEC, LOOP*: 3 cycles.
  - INCDP, DECDP: 1 cycle.
  - OUT, IN: 3 or 1 cycles respectively, plus the wait time.
- mem_re, mem_we, out_valid and in_ready are decoded combinationally from state, so they never assert in IDLE or HOLD.
- At most one of mem_re and mem_we is high in any cycle.
- Reset mid-operation, any state: IDLE on the next edge. A pending write or I/O transfer is abandoned, with no further mem_we, out_valid or in_ready.
- ack_in=1 while drdy=0 is ignored.

Decomposition:
- Opcode bit indices (OP_INC, OP_DEC, OP_INCDP, OP_DECDP, OP_OUT, OP_IN, OP_LOOPBEGIN, OP_LOOPEND) and OPCODE_MSB live in the shared Constants include.
- State encodings are local to the block.
- No sub-module required. The +/-1 arithmetic is a single expression.

Test Plan:
1. Memory cell 5 = 0xFF; op INC with dp=5 -> ack pulse; mem_re at addr 5; mem_we with wdata=0x00; drdy=1 with zero=1; held until ack_in.
2. Cell 7 = 0x00; op DEC with dp=7 -> write 0xFF, zero=0. Then LOOPBEGIN at dp=7 -> no mem_we, zero=0.
3. Cell 3 = 0x41; op OUT with out_ready=0 for 4 cycles, then 1 -> out_valid held for 5 cycles with out_data=0x41; single transfer; then drdy.
4. Op IN with in_valid arriving after 2 cycles, in_data=0x00 -> mem_we with wdata=0x00; zero=1; in_ready drops after the transfer.
5. Back-to-back: INCDP, then INC with ack_in held at 1 -> INCDP drdy 1 cycle after acceptance; second ack only after HOLD->IDLE; no memory access for INCDP.
6. Reset asserted in MODIFY of an INC and in OUT_WAIT -> next cycle all outputs 0, state IDLE, no mem_we or out transfer.
